mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath and memory word width.
REQ-002 Parameter MEM_ADDR_WIDTH, default 8, data-memory word-address width (256 words).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_halt  input  1  debug-unit freeze of this stage.
REQ-006 i_ex_m_alu_result  input  32  byte address for load/store, or result for R-type.
REQ-007 i_ex_m_write_data  input  32  store data.
REQ-008 i_ex_m_rd  input  5  destination register.
REQ-009 i_ex_m_mem_read / i_ex_m_mem_write / i_ex_m_mem_to_reg / i_ex_m_reg_write  input  1 each  control bits from the EX/MEM register.
REQ-010 i_du_mem_addr  input  MEM_ADDR_WIDTH  debug-unit word address.
REQ-011 o_du_mem_data  output  32  debug-unit read data.
REQ-012 o_m_wb_data  output  32  writeback data to the register file and EX forwarding.
REQ-013 o_m_wb_rd  output  5  writeback destination.
REQ-014 o_m_wb_reg_write  output  1  writeback enable.
REQ-015 o_misaligned  output  1  sticky misaligned-access flag.

Function
REQ-016 Word index SHALL be i_ex_m_alu_result[MEM_ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo 4*2^MEM_ADDR_WIDTH bytes.
REQ-017 Store: when mem_write=1, alignment bits [1:0]=0 and i_halt=0, the word SHALL be written at the rising edge.
REQ-018 Load: when mem_read=1, memory SHALL be read combinationally at the current index; a misaligned load SHALL read 0.
REQ-019 A misaligned access (mem_read or mem_write with [1:0]!=0) SHALL set o_misaligned at the next edge; it stays set until reset.
REQ-020 M/WB register SHALL capture read data, alu_result, rd, mem_to_reg and reg_write every edge unless i_halt=1, in which case all contents hold.
REQ-021 Captured reg_write SHALL be forced 0 when rd=0.
REQ-022 o_m_wb_data SHALL be the registered read data if registered mem_to_reg=1, else the registered alu_result; this mux is combinational from the register (no extra cycle).
REQ-023 Latency: one cycle from EX/MEM inputs to o_m_wb_* outputs.
REQ-024 Load immediately after a store to the same word SHALL return the newly stored data, because the write completes before the next read.
REQ-025 mem_read and mem_write both 1: the write SHALL take effect, and the captured read data SHALL be the old word.
REQ-026 Debug read: o_du_mem_data SHALL be registered, showing mem[i_du_mem_addr] one cycle after the address is applied; it is valid regardless of i_halt.
REQ-027 Debug read and pipeline store to the same word in the same cycle: o_du_mem_data SHALL show the old word.

Reset
REQ-028 While i_reset=0: o_m_wb_data=0, o_m_wb_rd=0, o_m_wb_reg_write=0, o_du_mem_data=0, o_misaligned=0, and all M/WB register fields are 0.
REQ-029 Memory contents SHALL NOT be affected by reset.
REQ-030 Reset asserted mid-store SHALL abort the write; asynchronous deassertion SHALL resume normal operation at the first following edge.

Structure
REQ-031 DATA_WIDTH, MEM_ADDR_WIDTH defaults and the register-index width (5) belong in the shared pipeline package.
REQ-032 Storage SHALL be a sub-module data_memory: one write port, one combinational read port, one registered debug read port.
REQ-033 The M/WB register and the writeback mux SHALL reside in mem_wb_stage.

Verification
REQ-034 Store 0xDEADBEEF at address 0x10, then load 0x10 with mem_to_reg=1, rd=8, reg_write=1 -> o_m_wb_data=0xDEADBEEF, rd=8, reg_write=1, one cycle after the load.
REQ-035 R-type with alu_result=0x00000123, rd=3, mem_to_reg=0 -> o_m_wb_data=0x123 after 1 cycle; the same with rd=0 -> o_m_wb_reg_write=0.
REQ-036 Store at address 0x13 -> memory unchanged (debug read of word 4 shows the old value) and o_misaligned=1 until reset.
REQ-037 Store 0x55 to address 0x400 with MEM_ADDR_WIDTH=8 -> debug read of word 0 returns 0x55 (wrap-around).
REQ-038 i_halt=1 for 3 cycles with a store presented -> outputs hold and memory is unchanged; the store happens after i_halt returns to 0.
REQ-039 Assert i_reset=0 asynchronously between edges -> all outputs 0 immediately; memory word written earlier is still readable after release.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline constants and types for the memory/writeback stage.
package mem_wb_stage_pkg;

    localparam int DATA_WIDTH_DEFAULT     = 32;
    localparam int MEM_ADDR_WIDTH_DEFAULT = 8;
    localparam int REG_IDX_WIDTH          = 5;

    typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     mem_to_reg;
        logic     reg_write;
    } wb_ctrl_t;

    // Word accesses need the two byte-offset bits clear.
    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return byte_offset != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs, debug read port and writeback outputs of the memory stage.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = mem_wb_stage_pkg::DATA_WIDTH_DEFAULT,
    parameter int MEM_ADDR_WIDTH = mem_wb_stage_pkg::MEM_ADDR_WIDTH_DEFAULT
) ();

    logic [DATA_WIDTH-1:0]     i_ex_m_alu_result;
    logic [DATA_WIDTH-1:0]     i_ex_m_write_data;
    reg_idx_t                  i_ex_m_rd;
    logic                      i_ex_m_mem_read;
    logic                      i_ex_m_mem_write;
    logic                      i_ex_m_mem_to_reg;
    logic                      i_ex_m_reg_write;
    logic [MEM_ADDR_WIDTH-1:0] i_du_mem_addr;

    logic [DATA_WIDTH-1:0]     o_du_mem_data;
    logic [DATA_WIDTH-1:0]     o_m_wb_data;
    reg_idx_t                  o_m_wb_rd;
    logic                      o_m_wb_reg_write;
    logic                      o_misaligned;

    modport master (
        output i_ex_m_alu_result, i_ex_m_write_data, i_ex_m_rd,
               i_ex_m_mem_read, i_ex_m_mem_write, i_ex_m_mem_to_reg,
               i_ex_m_reg_write, i_du_mem_addr,
        input  o_du_mem_data, o_m_wb_data, o_m_wb_rd, o_m_wb_reg_write,
               o_misaligned
    );

    modport slave (
        input  i_ex_m_alu_result, i_ex_m_write_data, i_ex_m_rd,
               i_ex_m_mem_read, i_ex_m_mem_write, i_ex_m_mem_to_reg,
               i_ex_m_reg_write, i_du_mem_addr,
        output o_du_mem_data, o_m_wb_data, o_m_wb_rd, o_m_wb_reg_write,
               o_misaligned
    );

endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: one write port, one combinational read port,
// one registered debug read port. Contents are never cleared by reset.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_write_en,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0] o_read_data,
    input  logic [ADDR_WIDTH-1:0] i_du_addr,
    output logic [DATA_WIDTH-1:0] o_du_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // A write presented while reset is held is dropped, but the array itself is untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset && i_write_en) begin
            mem[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = mem[i_read_addr];

    // Sampled before this edge's write lands, so a same-word collision shows the old word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_du_data <= '0;
        end else begin
            o_du_data <= mem[i_du_addr];
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access stage with the M/WB pipeline register and writeback mux.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = mem_wb_stage_pkg::DATA_WIDTH_DEFAULT,
    parameter int MEM_ADDR_WIDTH = mem_wb_stage_pkg::MEM_ADDR_WIDTH_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_halt,
    mem_wb_stage_if.slave bus
);

    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic                      offset_bad;
    logic                      misaligned_access;
    logic                      store_en;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic [DATA_WIDTH-1:0]     load_data;

    logic [DATA_WIDTH-1:0]     read_data_reg;
    logic [DATA_WIDTH-1:0]     alu_result_reg;
    wb_ctrl_t                  ctrl_reg;
    logic                      misaligned_reg;

    // Upper address bits are dropped, so byte addresses wrap around the memory.
    assign word_idx          = bus.i_ex_m_alu_result[MEM_ADDR_WIDTH+1:2];
    assign offset_bad        = is_misaligned(bus.i_ex_m_alu_result[1:0]);
    assign misaligned_access = offset_bad && (bus.i_ex_m_mem_read || bus.i_ex_m_mem_write);
    assign store_en          = bus.i_ex_m_mem_write && !offset_bad && !i_halt;
    assign load_data         = (bus.i_ex_m_mem_read && !offset_bad) ? mem_rdata : '0;

    data_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_data_memory (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_write_en   (store_en),
        .i_write_addr (word_idx),
        .i_write_data (bus.i_ex_m_write_data),
        .i_read_addr  (word_idx),
        .o_read_data  (mem_rdata),
        .i_du_addr    (bus.i_du_mem_addr),
        .o_du_data    (bus.o_du_mem_data)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            read_data_reg  <= '0;
            alu_result_reg <= '0;
            ctrl_reg       <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            if (!i_halt) begin
                read_data_reg       <= load_data;
                alu_result_reg      <= bus.i_ex_m_alu_result;
                ctrl_reg.rd         <= bus.i_ex_m_rd;
                ctrl_reg.mem_to_reg <= bus.i_ex_m_mem_to_reg;
                // x0 is hardwired, so never request a write to it.
                ctrl_reg.reg_write  <= bus.i_ex_m_reg_write && (bus.i_ex_m_rd != '0);
            end
            if (misaligned_access) begin
                misaligned_reg <= 1'b1;
            end
        end
    end

    assign bus.o_m_wb_data      = ctrl_reg.mem_to_reg ? read_data_reg : alu_result_reg;
    assign bus.o_m_wb_rd        = ctrl_reg.rd;
    assign bus.o_m_wb_reg_write = ctrl_reg.reg_write;
    assign bus.o_misaligned     = misaligned_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a word-array model predicts every output each cycle.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic halt  = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

    mem_wb_stage #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_halt  (halt),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: memory contents (with known flags) and expected outputs.
    logic [31:0] mem_model [256];
    bit          mem_known [256];
    logic [31:0] exp_data  = '0;
    bit          exp_data_valid = 1'b1;
    logic [4:0]  exp_rd    = '0;
    bit          exp_rw    = 1'b0;
    bit          exp_mis   = 1'b0;
    logic [31:0] exp_du    = '0;
    bit          exp_du_valid = 1'b1;
    bit          check_en  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        exp_data = '0; exp_data_valid = 1'b1;
        exp_rd = '0; exp_rw = 1'b0; exp_mis = 1'b0;
        exp_du = '0; exp_du_valid = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            if (exp_data_valid) chk("wb_data", bus.o_m_wb_data, exp_data);
            chk("wb_rd", 32'(bus.o_m_wb_rd), 32'(exp_rd));
            chk("wb_reg_write", 32'(bus.o_m_wb_reg_write), 32'(exp_rw));
            chk("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
            if (exp_du_valid) chk("du_data", bus.o_du_mem_data, exp_du);
        end
    end

    task automatic drive(input bit rd_en, input bit wr_en, input bit m2r, input bit rw,
                         input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input bit h, input logic [7:0] du);
        bus.i_ex_m_alu_result = alu;
        bus.i_ex_m_write_data = wdata;
        bus.i_ex_m_rd         = rd;
        bus.i_ex_m_mem_read   = rd_en;
        bus.i_ex_m_mem_write  = wr_en;
        bus.i_ex_m_mem_to_reg = m2r;
        bus.i_ex_m_reg_write  = rw;
        bus.i_du_mem_addr     = du;
        halt                  = h;
    endtask

    // One transaction: drive, predict from the model, take the edge, update model.
    task automatic cycle(input bit rd_en, input bit wr_en, input bit m2r, input bit rw,
                         input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input bit h, input logic [7:0] du);
        logic [7:0]  idx;
        bit          mis;
        logic [31:0] n_rdata, n_data, n_du;
        bit          n_rvalid, n_valid, n_du_valid, n_rw, n_mis;
        logic [4:0]  n_rd;
        drive(rd_en, wr_en, m2r, rw, alu, wdata, rd, h, du);
        idx = alu[9:2];
        mis = (alu[1:0] != 2'b00);
        n_data = exp_data; n_valid = exp_data_valid; n_rd = exp_rd; n_rw = exp_rw;
        if (!h) begin
            n_rdata  = (rd_en && !mis) ? mem_model[idx] : 32'h0;
            n_rvalid = (rd_en && !mis) ? mem_known[idx] : 1'b1;
            n_data   = m2r ? n_rdata : alu;
            n_valid  = m2r ? n_rvalid : 1'b1;
            n_rd     = rd;
            n_rw     = rw && (rd != 5'd0);
        end
        n_mis      = exp_mis || ((rd_en || wr_en) && mis);
        n_du       = mem_model[du];
        n_du_valid = mem_known[du];
        @(posedge clk);
        if (rst_n) begin
            exp_data = n_data; exp_data_valid = n_valid;
            exp_rd = n_rd; exp_rw = n_rw; exp_mis = n_mis;
            exp_du = n_du; exp_du_valid = n_du_valid;
            if (wr_en && !mis && !h) begin
                mem_model[idx] = wdata;
                mem_known[idx] = 1'b1;
            end
        end else begin
            model_reset();
        end
        #1;
        $display("txn t=%0t rd=%0b wr=%0b alu=0x%08h wd=0x%08h rd#=%0d halt=%0b du=%0d -> wb=0x%08h/%0d/%0b du=0x%08h mis=%0b",
                 $time, rd_en, wr_en, alu, wdata, rd, h, du,
                 bus.o_m_wb_data, bus.o_m_wb_rd, bus.o_m_wb_reg_write, bus.o_du_mem_data, bus.o_misaligned);
    endtask

    task automatic nop(input logic [7:0] du);
        cycle(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, du);
    endtask

    initial begin
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 8'd0);
        model_reset();
        check_en = 1'b1;

        // Reset state
        nop(8'd0);
        nop(8'd0);
        chk("reset_wb_data", bus.o_m_wb_data, 32'h0);
        chk("reset_wb_rw", 32'(bus.o_m_wb_reg_write), 32'h0);
        chk("reset_du", bus.o_du_mem_data, 32'h0);
        rst_n = 1'b1;
        nop(8'd0);

        // Store then load the same word
        cycle(0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0, 8'd4);
        cycle(1, 0, 1, 1, 32'h10, 32'h0, 5'd8, 0, 8'd4);
        chk("load_data", bus.o_m_wb_data, 32'hDEADBEEF);
        chk("load_rd", 32'(bus.o_m_wb_rd), 32'd8);
        chk("load_rw", 32'(bus.o_m_wb_reg_write), 32'd1);
        chk("load_du", bus.o_du_mem_data, 32'hDEADBEEF);

        // R-type, then rd=0 suppresses the write enable
        cycle(0, 0, 0, 1, 32'h123, 32'h0, 5'd3, 0, 8'd4);
        chk("rtype_data", bus.o_m_wb_data, 32'h123);
        chk("rtype_rw", 32'(bus.o_m_wb_reg_write), 32'd1);
        cycle(0, 0, 0, 1, 32'h123, 32'h0, 5'd0, 0, 8'd4);
        chk("rd0_rw", 32'(bus.o_m_wb_reg_write), 32'd0);

        // Address wrap-around
        cycle(0, 1, 0, 0, 32'h400, 32'h55, 5'd0, 0, 8'd0);
        nop(8'd0);
        chk("wrap_du", bus.o_du_mem_data, 32'h55);

        // Read+write same word returns old data; following load sees new data
        cycle(1, 1, 1, 1, 32'h0, 32'h77, 5'd5, 0, 8'd0);
        chk("rw_old", bus.o_m_wb_data, 32'h55);
        cycle(1, 0, 1, 1, 32'h0, 32'h0, 5'd6, 0, 8'd0);
        chk("load_after_store", bus.o_m_wb_data, 32'h77);
        chk("du_after_store", bus.o_du_mem_data, 32'h77);

        // Debug read colliding with a store shows the old word
        cycle(0, 1, 0, 0, 32'h10, 32'h11112222, 5'd0, 0, 8'd4);
        chk("du_collision", bus.o_du_mem_data, 32'hDEADBEEF);
        nop(8'd4);
        chk("du_after_collision", bus.o_du_mem_data, 32'h11112222);

        // Halt freezes the stage and blocks the store
        cycle(0, 0, 0, 1, 32'hABC, 32'h0, 5'd9, 0, 8'd4);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 32'h10, 32'hCAFEF00D, 5'd12, 1, 8'd4);
            chk("halt_data", bus.o_m_wb_data, 32'hABC);
            chk("halt_rd", 32'(bus.o_m_wb_rd), 32'd9);
            chk("halt_du", bus.o_du_mem_data, 32'h11112222);
        end
        cycle(0, 1, 0, 1, 32'h10, 32'hCAFEF00D, 5'd12, 0, 8'd4);
        chk("unhalt_rd", 32'(bus.o_m_wb_rd), 32'd12);
        nop(8'd4);
        chk("unhalt_store", bus.o_du_mem_data, 32'hCAFEF00D);

        // Misaligned store and load
        cycle(0, 1, 0, 0, 32'h13, 32'hBAD, 5'd0, 0, 8'd4);
        chk("mis_set", 32'(bus.o_misaligned), 32'd1);
        cycle(1, 0, 1, 1, 32'h12, 32'h0, 5'd7, 0, 8'd4);
        chk("mis_load_zero", bus.o_m_wb_data, 32'h0);
        chk("mis_mem_unchanged", bus.o_du_mem_data, 32'hCAFEF00D);
        nop(8'd4);
        chk("mis_sticky", 32'(bus.o_misaligned), 32'd1);

        // Asynchronous reset mid-store aborts the write; memory survives
        drive(0, 1, 0, 1, 32'h10, 32'h99999999, 5'd4, 0, 8'd4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_wb_data", bus.o_m_wb_data, 32'h0);
        chk("async_mis", 32'(bus.o_misaligned), 32'h0);
        chk("async_du", bus.o_du_mem_data, 32'h0);
        cycle(0, 1, 0, 1, 32'h10, 32'h99999999, 5'd4, 0, 8'd4);
        #2;
        rst_n = 1'b1;
        nop(8'd4);
        chk("post_reset_mem", bus.o_du_mem_data, 32'hCAFEF00D);
        chk("post_reset_mis", 32'(bus.o_misaligned), 32'd0);
        nop(8'd0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
